// File: rtl/clk_div_switch_if.sv
// rtl/clk_div_switch_if.sv - ratio request handshake between a controller and the divider
interface clk_div_switch_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_ratio;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ratio,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ratio,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_switch.sv
// rtl/clk_div_switch.sv - glitch-free programmable clock divider with period-boundary ratio switching
module clk_div_switch #(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    clk_div_switch_if.slave  cfg,
    output logic             clk_out,
    output logic             period_start,
    output logic [DIV_W-1:0] cur_ratio
);

    localparam logic [DIV_W-1:0] RST_RATIO = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] RST_CNT   = DIV_W'(RST_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_ratio;
    logic [DIV_W-1:0] pend_ratio;
    logic             pend;
    logic             clk_out_q;
    logic             period_start_q;
    logic             cfg_err_q;

    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] act_ratio_nxt;
    logic [DIV_W-1:0] pend_ratio_nxt;
    logic             pend_nxt;
    logic             clk_out_nxt;
    logic             period_start_nxt;
    logic             cfg_err_nxt;

    logic             at_last;
    logic             wrap;
    logic             accept;
    logic             ratio_ok;

    // A period only ends when en is seen at the last count, so phases are never shortened.
    assign at_last  = (cnt == act_ratio - DIV_W'(1));
    assign wrap     = at_last && en;
    assign accept   = cfg.cfg_valid && !pend;
    assign ratio_ok = (cfg.cfg_ratio >= DIV_W'(2));

    // Next-state: counter, ratio swap at wrap, request capture, and output levels from next-state values.
    always_comb begin
        cnt_nxt          = cnt;
        act_ratio_nxt    = act_ratio;
        pend_ratio_nxt   = pend_ratio;
        pend_nxt         = pend;
        cfg_err_nxt      = 1'b0;
        period_start_nxt = wrap;

        if (!at_last) begin
            cnt_nxt = cnt + DIV_W'(1);
        end else if (en) begin
            cnt_nxt = '0;
        end

        // Wrap and accept are mutually exclusive (one needs pend, the other !pend),
        // so a request landing on the wrap edge waits for the following wrap.
        if (wrap && pend) begin
            act_ratio_nxt = pend_ratio;
            pend_nxt      = 1'b0;
        end

        if (accept) begin
            if (ratio_ok) begin
                pend_ratio_nxt = cfg.cfg_ratio;
                pend_nxt       = 1'b1;
            end else begin
                cfg_err_nxt = 1'b1;
            end
        end

        clk_out_nxt = (cnt_nxt < (act_ratio_nxt >> 1));
    end

    // State register; reset parks the divider at the end of a low phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt            <= RST_CNT;
            act_ratio      <= RST_RATIO;
            pend_ratio     <= RST_RATIO;
            pend           <= 1'b0;
            clk_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            act_ratio      <= act_ratio_nxt;
            pend_ratio     <= pend_ratio_nxt;
            pend           <= pend_nxt;
            clk_out_q      <= clk_out_nxt;
            period_start_q <= period_start_nxt;
            cfg_err_q      <= cfg_err_nxt;
        end
    end

    assign clk_out       = clk_out_q;
    assign period_start  = period_start_q;
    assign cur_ratio     = act_ratio;
    assign cfg.cfg_ready = !pend;
    assign cfg.cfg_err   = cfg_err_q;

endmodule
